// File: rtl/fwd_scoreboard.sv
// Operand-bypass and load-use hazard controller: tracks in-flight destination registers
// over DEPTH stages, picks the youngest producer per source. Optional FWD_STALL_CNT_EN adds stall_cnt.
module fwd_scoreboard #(
    parameter int REG_BITS    = 5,
    parameter int DEPTH       = 3,
    parameter int NSRC        = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int SELW        = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     iss_valid,
    input  logic [REG_BITS-1:0]      iss_rd,
    input  logic [SELW-1:0]          iss_rdy_at,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*REG_BITS-1:0] src_addr,
    input  logic                     flush,
    output logic [NSRC*SELW-1:0]     fwd_sel,
    output logic                     stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    // Out-of-range ready stages are folded into 1..DEPTH before being stored.
    function automatic logic [SELW-1:0] clamp_rdy(input logic [SELW-1:0] rdy);
        logic [SELW-1:0] res;
        if (rdy == '0) begin
            res = SELW'(1);
        end else if (rdy > SELW'(DEPTH)) begin
            res = SELW'(DEPTH);
        end else begin
            res = rdy;
        end
        return res;
    endfunction

    logic [DEPTH:1]    v_q, v_d, v_shift_s;
    logic [REG_BITS-1:0] rd_q  [1:DEPTH];
    logic [REG_BITS-1:0] rd_d  [1:DEPTH];
    logic [SELW-1:0]     rdy_q [1:DEPTH];
    logic [SELW-1:0]     rdy_d [1:DEPTH];
    logic [NSRC-1:0]     hazard_s;
    logic                stall_s;

    // Youngest-match search per source; a not-yet-ready winner blocks older ready entries.
    always_comb begin
        logic                found;
        logic [REG_BITS-1:0] addr;
        fwd_sel  = '0;
        hazard_s = '0;
        for (int s = 0; s < NSRC; s++) begin
            found = 1'b0;
            addr  = src_addr[s*REG_BITS +: REG_BITS];
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && src_valid[s] && v_q[k] && (rd_q[k] == addr) && (addr != '0)) begin
                    found = 1'b1;
                    if (SELW'(k) >= rdy_q[k]) begin
                        fwd_sel[s*SELW +: SELW] = SELW'(k);
                    end else begin
                        hazard_s[s] = 1'b1;
                    end
                end else begin
                    found = found;
                end
            end
        end
        stall_s = (|hazard_s) & ~flush;
        stall   = stall_s;
    end

    // Next pipe contents: always shift, bubble on stall, kill the young stages on flush.
    always_comb begin
        v_shift_s    = '0;
        v_d          = '0;
        v_shift_s[1] = iss_valid & ~stall_s & ~flush & (iss_rd != '0);
        rd_d[1]      = iss_rd;
        rdy_d[1]     = clamp_rdy(iss_rdy_at);
        for (int k = 2; k <= DEPTH; k++) begin
            v_shift_s[k] = v_q[k-1];
            rd_d[k]      = rd_q[k-1];
            rdy_d[k]     = rdy_q[k-1];
        end
        for (int k = 1; k <= DEPTH; k++) begin
            if (flush && (k <= FLUSH_DEPTH)) begin
                v_d[k] = 1'b0;
            end else begin
                v_d[k] = v_shift_s[k];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k]  <= '0;
                rdy_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k]  <= rd_d[k];
                rdy_q[k] <= rdy_d[k];
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall-cycle count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomised and directed bench for fwd_scoreboard against an age-based queue model.
module tb_fwd_scoreboard;
    localparam int REG_BITS    = 5;
    localparam int DEPTH       = 3;
    localparam int NSRC        = 2;
    localparam int FLUSH_DEPTH = 1;
    localparam int SELW        = 2;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     iss_valid = 1'b0;
    logic [REG_BITS-1:0]      iss_rd = '0;
    logic [SELW-1:0]          iss_rdy_at = '0;
    logic [NSRC-1:0]          src_valid = '0;
    logic [NSRC*REG_BITS-1:0] src_addr = '0;
    logic                     flush = 1'b0;
    logic [NSRC*SELW-1:0]     fwd_sel;
    logic                     stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    fwd_scoreboard #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .NSRC(NSRC), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_rdy_at(iss_rdy_at), .src_valid(src_valid), .src_addr(src_addr), .flush(flush),
        .fwd_sel(fwd_sel), .stall(stall)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {int rd; int rdy; int age;} ent_t;
    ent_t mq[$];
    int   m_cnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Expected outputs: among in-flight writers of a source register, the lowest age wins.
    function automatic void model_out(output logic [NSRC*SELW-1:0] sel, output logic st);
        sel = '0;
        st  = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            int a;
            int best;
            int brdy;
            a    = int'(src_addr[s*REG_BITS +: REG_BITS]);
            best = 0;
            brdy = 0;
            if (src_valid[s] && a != 0) begin
                foreach (mq[i]) begin
                    if (mq[i].rd == a && (best == 0 || mq[i].age < best)) begin
                        best = mq[i].age;
                        brdy = mq[i].rdy;
                    end
                end
            end
            if (best != 0) begin
                if (best >= brdy) sel[s*SELW +: SELW] = SELW'(best);
                else st = 1'b1;
            end
        end
        if (flush) st = 1'b0;
    endfunction

    task automatic model_step();
        logic [NSRC*SELW-1:0] sel;
        logic st;
        ent_t nq[$];
        ent_t e;
        int r;
        if (!reset_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            model_out(sel, st);
            if (st && m_cnt < 65535) m_cnt++;
            foreach (mq[i]) begin
                e = mq[i];
                e.age++;
                if (e.age <= DEPTH && !(flush && e.age <= FLUSH_DEPTH)) nq.push_back(e);
            end
            if (iss_valid && !st && !flush && iss_rd != 0) begin
                r = int'(iss_rdy_at);
                if (r < 1) r = 1;
                if (r > DEPTH) r = DEPTH;
                e.rd  = int'(iss_rd);
                e.rdy = r;
                e.age = 1;
                nq.push_back(e);
            end
            mq = nq;
        end
    endtask

    // Per-cycle compare of every output against the model, away from the clock edge.
    task automatic cycle_check();
        logic [NSRC*SELW-1:0] sel;
        logic st;
        @(negedge clock);
        #1;
        if (!reset_n) begin
            sel = '0;
            st  = 1'b0;
        end else begin
            model_out(sel, st);
        end
        chk("model_fwd_sel", 32'(fwd_sel), 32'(sel));
        chk("model_stall", 32'(stall), 32'(st));
`ifdef FWD_STALL_CNT_EN
        chk("model_stall_cnt", 32'(stall_cnt), reset_n ? 32'(m_cnt) : 32'd0);
`endif
    endtask

    task automatic adv();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drv(input logic iv, input logic [4:0] rd, input logic [1:0] rdy,
                       input logic [1:0] sv, input logic [4:0] a0, input logic [4:0] a1,
                       input logic fl);
        iss_valid  = iv;
        iss_rd     = rd;
        iss_rdy_at = rdy;
        src_valid  = sv;
        src_addr   = {a1, a0};
        flush      = fl;
    endtask

    task automatic load_use_episode(input logic [4:0] rd, input string nm);
        drv(1'b1, rd, 2'd3, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b01, rd, 5'd0, 1'b0);
        cycle_check(); chk({nm, "_s1"}, 32'(stall), 32'd1); adv();
        cycle_check(); chk({nm, "_s2"}, 32'(stall), 32'd1); adv();
        cycle_check(); chk({nm, "_rdy"}, 32'(stall), 32'd0); chk({nm, "_sel"}, 32'(fwd_sel[1:0]), 32'd3);
    endtask

    initial begin
        // Reset state, then first cycle after release.
        cycle_check(); chk("rst_sel", 32'(fwd_sel), 32'd0); chk("rst_stall", 32'(stall), 32'd0);
        adv();
        reset_n = 1'b1;
        drv(1'b0, 5'd0, 2'd0, 2'b11, 5'd1, 5'd2, 1'b0);
        cycle_check(); chk("post_rst_sel", 32'(fwd_sel), 32'd0); adv();

        // ALU chain.
        drv(1'b1, 5'd5, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b01, 5'd5, 5'd0, 1'b0);
        cycle_check(); chk("alu_x", 32'(fwd_sel[1:0]), 32'd1); chk("alu_x_stall", 32'(stall), 32'd0); adv();
        cycle_check(); chk("alu_m", 32'(fwd_sel[1:0]), 32'd2); adv();
        cycle_check(); chk("alu_w", 32'(fwd_sel[1:0]), 32'd3); adv();
        cycle_check(); chk("alu_gone", 32'(fwd_sel[1:0]), 32'd0); adv();

        // Load-use.
        drv(1'b1, 5'd7, 2'd2, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b10, 5'd0, 5'd7, 1'b0);
        cycle_check(); chk("lu_stall", 32'(stall), 32'd1); chk("lu_sel", 32'(fwd_sel[3:2]), 32'd0); adv();
        cycle_check(); chk("lu_release", 32'(stall), 32'd0); chk("lu_fwd", 32'(fwd_sel[3:2]), 32'd2); adv();

        // Zero register.
        drv(1'b1, 5'd0, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b11, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_check(); chk("zero_sel", 32'(fwd_sel), 32'd0); chk("zero_stall", 32'(stall), 32'd0); adv();
        end

        // Youngest wins.
        drv(1'b1, 5'd3, 2'd1, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b01, 5'd3, 5'd0, 1'b0);
        cycle_check(); chk("youngest", 32'(fwd_sel[1:0]), 32'd1); adv();

        // Flush beats issue and stall.
        drv(1'b1, 5'd9, 2'd2, 2'b01, 5'd9, 5'd0, 1'b1);
        cycle_check(); chk("flush_stall", 32'(stall), 32'd0); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b01, 5'd9, 5'd0, 1'b0);
        cycle_check(); chk("flush_killed", 32'(fwd_sel[1:0]), 32'd0); chk("flush_nostall", 32'(stall), 32'd0); adv();

        // Randomised traffic over a small register window to provoke hits.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0));
            cycle_check();
            adv();
        end

        // Stall counting from a clean reset, then reset mid-stall.
        drv(1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 1'b0);
        reset_n = 1'b0;
        cycle_check(); adv();
        reset_n = 1'b1;
        load_use_episode(5'd4, "cnt_a"); adv();
        load_use_episode(5'd6, "cnt_b");
`ifdef FWD_STALL_CNT_EN
        chk("cnt_four", 32'(stall_cnt), 32'd4);
`endif
        adv();
        drv(1'b1, 5'd8, 2'd3, 2'b00, 5'd0, 5'd0, 1'b0); cycle_check(); adv();
        drv(1'b0, 5'd0, 2'd0, 2'b01, 5'd8, 5'd0, 1'b0);
        cycle_check(); chk("pre_rst_stall", 32'(stall), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_sel", 32'(fwd_sel), 32'd0);
`ifdef FWD_STALL_CNT_EN
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
`endif
        adv();
        reset_n = 1'b1;
        cycle_check(); adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
